ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 144 ++++++++++++++
 tb/tb_ram_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester round-robin arbiter in front of a 16x8 synchronous RAM
module ram_arbiter (
    input  logic       clk,
    input  logic       areset,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [3:0] addr0,
    input  logic [3:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       rvalid0,
    output logic       rvalid1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic       mem_en,
    output logic       mem_we,
    output logic [3:0] mem_addr,
    output logic [7:0] mem_din,
    input  logic [7:0] mem_dout,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCESS    = 2'd1,
        READ_WAIT = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_last;     // 1 = requester 1 was granted most recently
    logic       r_win;      // requester owning the access in flight
    logic       w_any;
    logic       w_pick;     // winner chosen this cycle when in IDLE

    logic       r_gnt0;
    logic       r_gnt1;
    logic       r_rvalid0;
    logic       r_rvalid1;
    logic [7:0] r_rdata0;
    logic [7:0] r_rdata1;
    logic       r_mem_en;
    logic       r_mem_we;
    logic [3:0] r_mem_addr;
    logic [7:0] r_mem_din;
    logic       r_busy;

    // Winner selection and next-state decode
    always_comb begin
        w_any  = req0 | req1;
        w_pick = 1'b0;
        w_next = r_state;
        if (req0 && req1) begin
            w_pick = ~r_last;
        end else if (req1) begin
            w_pick = 1'b1;
        end
        case (r_state)
            IDLE:      if (w_any) w_next = ACCESS;
            // r_mem_we holds the latched command type throughout ACCESS
            ACCESS:    w_next = r_mem_we ? IDLE : READ_WAIT;
            READ_WAIT: w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (areset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Registered outputs: grant/memory command launched on the IDLE->ACCESS edge, read data captured leaving READ_WAIT
    always_ff @(posedge clk) begin
        if (areset) begin
            r_last     <= 1'b1;
            r_win      <= 1'b0;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_rdata0   <= 8'h00;
            r_rdata1   <= 8'h00;
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= 4'h0;
            r_mem_din  <= 8'h00;
            r_busy     <= 1'b0;
        end else begin
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_mem_en  <= 1'b0;
            r_mem_we  <= 1'b0;
            r_busy    <= (w_next != IDLE);
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_win      <= w_pick;
                        r_last     <= w_pick;
                        r_gnt0     <= ~w_pick;
                        r_gnt1     <= w_pick;
                        r_mem_en   <= 1'b1;
                        r_mem_we   <= w_pick ? we1 : we0;
                        r_mem_addr <= w_pick ? addr1 : addr0;
                        r_mem_din  <= w_pick ? wdata1 : wdata0;
                    end
                end
                READ_WAIT: begin
                    if (r_win) begin
                        r_rdata1  <= mem_dout;
                        r_rvalid1 <= 1'b1;
                    end else begin
                        r_rdata0  <= mem_dout;
                        r_rvalid0 <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign gnt0     = r_gnt0;
    assign gnt1     = r_gnt1;
    assign rvalid0  = r_rvalid0;
    assign rvalid1  = r_rvalid1;
    assign rdata0   = r_rdata0;
    assign rdata1   = r_rdata1;
    assign mem_en   = r_mem_en;
    assign mem_we   = r_mem_we;
    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;
    assign busy     = r_busy;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       areset;
    logic       req0, req1, we0, we1;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata0, rdata1;
    logic       mem_en, mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] ram [16];
    logic [7:0] ram_dout;

    ram_arbiter dut (
        .clk      (clk),
        .areset   (areset),
        .req0     (req0),
        .req1     (req1),
        .we0      (we0),
        .we1      (we1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: write on en&we, registered read on en&!we
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_din;
            else        ram_dout      <= ram[mem_addr];
        end
    end
    assign mem_dout = ram_dout;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = 4'd0; addr1 = 4'd0; wdata0 = 8'h00; wdata1 = 8'h00;
        tick();
        tick();
        tick();
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, busy} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000000", {gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, busy});
        end
        checks++;
        if ({rdata0, rdata1, mem_addr, mem_din} !== 28'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {rdata0, rdata1, mem_addr, mem_din});
        end
        req0 = 1'b0; req1 = 1'b0;
        areset = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd3; wdata0 = 8'hA5;
        tick();
        req0 = 1'b0;
        checks++;
        if ({gnt0, gnt1, mem_en, mem_we, busy} !== 5'b10111) begin
            errors++;
            $display("FAIL wr_access_ctrl: got %b expected 10111", {gnt0, gnt1, mem_en, mem_we, busy});
        end
        checks++;
        if ({mem_addr, mem_din} !== {4'd3, 8'hA5}) begin
            errors++;
            $display("FAIL wr_access_cmd: got %h/%h expected 3/a5", mem_addr, mem_din);
        end
        tick();
        checks++;
        if ({gnt0, mem_en, mem_we, busy, mem_addr} !== {4'b0000, 4'd3}) begin
            errors++;
            $display("FAIL wr_idle: got %b expected 00000011", {gnt0, mem_en, mem_we, busy, mem_addr});
        end
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3;
        tick();
        req0 = 1'b0;
        checks++;
        if ({gnt0, gnt1, mem_en, mem_we, busy} !== 5'b10101) begin
            errors++;
            $display("FAIL rd_access_ctrl: got %b expected 10101", {gnt0, gnt1, mem_en, mem_we, busy});
        end
        tick();
        checks++;
        if ({gnt0, rvalid0, mem_en, busy} !== 4'b0001) begin
            errors++;
            $display("FAIL rd_wait: got %b expected 0001", {gnt0, rvalid0, mem_en, busy});
        end
        tick();
        checks++;
        if ({rvalid0, rvalid1, busy, rdata0} !== {3'b100, 8'hA5}) begin
            errors++;
            $display("FAIL rd_valid: got rv=%b%b busy=%b rdata0=%h expected 1 0 0 a5", rvalid0, rvalid1, busy, rdata0);
        end
        tick();
        checks++;
        if ({rvalid0, rdata0} !== {1'b0, 8'hA5}) begin
            errors++;
            $display("FAIL rd_hold: got rv=%b rdata0=%h expected 0 a5", rvalid0, rdata0);
        end
    endtask

    task automatic test_tie();
        logic [3:0] exp;
        areset = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd3;
        tick();
        tick();
        checks++;
        if ({gnt0, gnt1, busy} !== 3'b000) begin
            errors++;
            $display("FAIL tie_held_in_reset: got %b expected 000", {gnt0, gnt1, busy});
        end
        areset = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            exp = {(c % 6 == 1), (c % 6 == 4), (c % 6 == 3), (c % 6 == 0)};
            checks++;
            if ({gnt0, gnt1, rvalid0, rvalid1} !== exp) begin
                errors++;
                $display("FAIL tie_cycle%0d: got g0g1v0v1=%b expected %b", c, {gnt0, gnt1, rvalid0, rvalid1}, exp);
            end
            if (c == 3 || c == 6) begin
                checks++;
                if ((c == 3 ? rdata0 : rdata1) !== 8'hA5) begin
                    errors++;
                    $display("FAIL tie_rdata_cycle%0d: got %h expected a5", c, (c == 3 ? rdata0 : rdata1));
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_read();
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3;
        tick();
        req0 = 1'b0;
        checks++;
        if (gnt0 !== 1'b1) begin
            errors++;
            $display("FAIL mid_grant: got gnt0=%b expected 1", gnt0);
        end
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_readwait_busy: got %b expected 1", busy);
        end
        areset = 1'b1;
        tick();
        checks++;
        if ({rvalid0, rvalid1, busy, rdata0, rdata1} !== 19'h0) begin
            errors++;
            $display("FAIL mid_abort: got rv=%b%b busy=%b rd0=%h rd1=%h expected all 0", rvalid0, rvalid1, busy, rdata0, rdata1);
        end
        areset = 1'b0;
        req0 = 1'b1; req1 = 1'b1; we1 = 1'b0; addr1 = 4'd3;
        tick();
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b1000) begin
            errors++;
            $display("FAIL mid_after_reset_tie: got %b expected 1000", {gnt0, gnt1, rvalid0, rvalid1});
        end
        req0 = 1'b0;
        tick();
        tick();
        checks++;
        if ({rvalid0, rvalid1} !== 2'b10) begin
            errors++;
            $display("FAIL mid_rvalid0: got %b expected 10", {rvalid0, rvalid1});
        end
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b01) begin
            errors++;
            $display("FAIL mid_gnt1: got %b expected 01", {gnt0, gnt1});
        end
        req1 = 1'b0;
        tick();
        tick();
        checks++;
        if ({rvalid0, rvalid1, rdata1} !== {2'b01, 8'hA5}) begin
            errors++;
            $display("FAIL mid_rvalid1: got %b rd1=%h expected 01 a5", {rvalid0, rvalid1}, rdata1);
        end
        tick();
    endtask

    task automatic test_sole_req1();
        req1 = 1'b1; we1 = 1'b1; addr1 = 4'd15; wdata1 = 8'hFF;
        for (int c = 1; c <= 8; c++) begin
            tick();
            checks++;
            if ({gnt0, gnt1, mem_en} !== {1'b0, (c % 2 == 1), (c % 2 == 1)}) begin
                errors++;
                $display("FAIL sole_cycle%0d: got g0g1en=%b expected 0%0d%0d", c, {gnt0, gnt1, mem_en}, c % 2, c % 2);
            end
            if (c == 7) req1 = 1'b0;
        end
        checks++;
        if ({mem_addr, ram[15]} !== {4'd15, 8'hFF}) begin
            errors++;
            $display("FAIL sole_mem15: got addr=%h word15=%h expected f ff", mem_addr, ram[15]);
        end
    endtask

    task automatic test_back_to_back();
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd0; wdata0 = 8'h11;
        req1 = 1'b1; we1 = 1'b1; addr1 = 4'd1; wdata1 = 8'h22;
        tick();
        req0 = 1'b0;
        checks++;
        if ({gnt0, gnt1, mem_en, mem_we, mem_addr, mem_din} !== {4'b1011, 4'd0, 8'h11}) begin
            errors++;
            $display("FAIL b2b_first: got %b a=%h d=%h expected 1011 0 11", {gnt0, gnt1, mem_en, mem_we}, mem_addr, mem_din);
        end
        tick();
        checks++;
        if ({mem_en, busy} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_gap: got en/busy=%b expected 00", {mem_en, busy});
        end
        tick();
        req1 = 1'b0;
        checks++;
        if ({gnt0, gnt1, mem_en, mem_we, mem_addr, mem_din} !== {4'b0111, 4'd1, 8'h22}) begin
            errors++;
            $display("FAIL b2b_second: got %b a=%h d=%h expected 0111 1 22", {gnt0, gnt1, mem_en, mem_we}, mem_addr, mem_din);
        end
        tick();
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd1;
        tick();
        req0 = 1'b0;
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_rd_grant: got %b expected 10", {gnt0, gnt1});
        end
        tick();
        tick();
        checks++;
        if ({rvalid0, rvalid1, rdata0} !== {2'b10, 8'h11}) begin
            errors++;
            $display("FAIL b2b_rd0: got %b rd0=%h expected 10 11", {rvalid0, rvalid1}, rdata0);
        end
        tick();
        req1 = 1'b0;
        tick();
        tick();
        checks++;
        if ({rvalid0, rvalid1, rdata1, rdata0} !== {2'b01, 8'h22, 8'h11}) begin
            errors++;
            $display("FAIL b2b_rd1: got %b rd1=%h rd0=%h expected 01 22 11", {rvalid0, rvalid1}, rdata1, rdata0);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_tie();
        test_reset_mid_read();
        test_sole_req1();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
